// File: rtl/eth_rx_frame_analyzer_nd.sv
// eth_rx_frame_analyzer_nd: GMII receive-side frame analyzer.
// Follows preamble/SFD/data framing and reports each frame's length and error flags.
// Also provides a fixed-latency copy of the raw GMII inputs.
// FCS (CRC-32) checking is compiled in only when ETH_RX_FCS_CHECK_EN is defined.
// Without it, o_fcs_err is tied low.
`timescale 1ns/1ps
module eth_rx_frame_analyzer_nd #(
    parameter int pDELAY   = 4,
    parameter int pPRE_MIN = 7,
    parameter int pMIN_LEN = 64,
    parameter int pMAX_LEN = 1518
) (
    input  logic        i_rx_clk,
    input  logic        i_rst_n,
    input  logic        i_rx_dv,
    input  logic        i_rx_er,
    input  logic [7:0]  i_rx_d,
    output logic [2:0]  o_fsm_state,
    output logic        o_fsm_state_changed,
    output logic        o_rx_dv_dly,
    output logic        o_rx_er_dly,
    output logic [7:0]  o_rx_d_dly,
    output logic [15:0] o_frame_len,
    output logic        o_frame_done,
    output logic        o_frame_ok,
    output logic        o_len_err,
    output logic        o_fcs_err,
    output logic        o_frame_abort
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_SFD      = 3'd2,
        ST_DATA     = 3'd3,
        ST_END      = 3'd4,
        ST_ERROR    = 3'd5
    } state_t;

    localparam logic [3:0]  cPreMin = 4'(pPRE_MIN);
    localparam logic [15:0] cMinLen = 16'(pMIN_LEN);
    localparam logic [15:0] cMaxLen = 16'(pMAX_LEN);

    state_t      state_q, state_d;
    logic [3:0]  preCnt_q, preCnt_d;
    logic [15:0] len_q, len_d;
    logic [15:0] frameLen_q;
    logic        changed_q, done_q, ok_q, lenErr_q, fcsErr_q, abort_q;
    logic [9:0]  dly_q [pDELAY];
    logic        endNext, lenBad, fcsBad;

    // Next-state decode: each byte sampled at the edge decides where the framer goes.
    always_comb begin
        state_d  = ST_IDLE;
        preCnt_d = preCnt_q;
        len_d    = len_q;
        case (state_q)
            ST_IDLE, ST_END: begin
                if (!i_rx_dv) begin
                    state_d = ST_IDLE;
                end else if (!i_rx_er && i_rx_d == 8'h55) begin
                    state_d  = ST_PREAMBLE;
                    preCnt_d = 4'd1;
                end else begin
                    state_d = ST_ERROR;
                end
            end
            ST_PREAMBLE: begin
                if (!i_rx_dv) begin
                    state_d = ST_IDLE;
                end else if (i_rx_er) begin
                    state_d = ST_ERROR;
                end else if (i_rx_d == 8'h55) begin
                    state_d = ST_PREAMBLE;
                    if (preCnt_q != 4'hF) preCnt_d = preCnt_q + 4'd1;
                end else if (i_rx_d == 8'hD5 && preCnt_q >= cPreMin) begin
                    state_d = ST_SFD;
                end else begin
                    state_d = ST_ERROR;
                end
            end
            ST_SFD: begin
                if (!i_rx_dv) begin
                    state_d = ST_END;
                    len_d   = 16'd0;
                end else if (i_rx_er) begin
                    state_d = ST_ERROR;
                end else begin
                    state_d = ST_DATA;
                    len_d   = 16'd1;
                end
            end
            ST_DATA: begin
                if (!i_rx_dv) begin
                    state_d = ST_END;
                end else if (i_rx_er) begin
                    state_d = ST_ERROR;
                end else begin
                    state_d = ST_DATA;
                    if (len_q != 16'hFFFF) len_d = len_q + 16'd1;
                end
            end
            ST_ERROR: begin
                state_d = i_rx_dv ? ST_ERROR : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign endNext = (state_d == ST_END);
    assign lenBad  = (len_d < cMinLen) || (len_d > cMaxLen);

`ifdef ETH_RX_FCS_CHECK_EN
    logic [31:0] crc_q;

    function automatic logic [31:0] crcByte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {24'd0, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    function automatic logic [31:0] bitRev(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31 - i];
        return r;
    endfunction

    // CRC runs only across DATA bytes and rests at its seed otherwise, so every frame starts clean.
    always_ff @(posedge i_rx_clk) begin
        if (!i_rst_n) begin
            crc_q <= 32'hFFFFFFFF;
        end else if (state_d == ST_DATA) begin
            crc_q <= crcByte(crc_q, i_rx_d);
        end else begin
            crc_q <= 32'hFFFFFFFF;
        end
    end

    // The register is kept bit-reflected; reversing it yields the familiar MSB-first residue.
    assign fcsBad = (bitRev(crc_q) != 32'hC704DD7B);
`else
    assign fcsBad = 1'b0;
`endif

    // Framer state plus all status outputs, registered together so they line up with the state.
    always_ff @(posedge i_rx_clk) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            preCnt_q   <= 4'd0;
            len_q      <= 16'd0;
            frameLen_q <= 16'd0;
            changed_q  <= 1'b0;
            done_q     <= 1'b0;
            ok_q       <= 1'b0;
            lenErr_q   <= 1'b0;
            fcsErr_q   <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            preCnt_q  <= preCnt_d;
            len_q     <= len_d;
            changed_q <= (state_d != state_q);
            done_q    <= endNext;
            ok_q      <= endNext && !lenBad && !fcsBad;
            lenErr_q  <= endNext && lenBad;
            fcsErr_q  <= endNext && fcsBad;
            abort_q   <= (state_d == ST_ERROR) && (state_q != ST_ERROR);
            if (endNext) frameLen_q <= len_d;
        end
    end

    // Raw GMII delay line, independent of framing; stage 0 holds the byte sampled at this edge.
    always_ff @(posedge i_rx_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < pDELAY; i++) dly_q[i] <= 10'd0;
        end else begin
            dly_q[0] <= {i_rx_dv, i_rx_er, i_rx_d};
            for (int i = 1; i < pDELAY; i++) dly_q[i] <= dly_q[i - 1];
        end
    end

    assign o_fsm_state         = state_q;
    assign o_fsm_state_changed = changed_q;
    assign o_rx_dv_dly         = dly_q[pDELAY - 1][9];
    assign o_rx_er_dly         = dly_q[pDELAY - 1][8];
    assign o_rx_d_dly          = dly_q[pDELAY - 1][7:0];
    assign o_frame_len         = frameLen_q;
    assign o_frame_done        = done_q;
    assign o_frame_ok          = ok_q;
    assign o_len_err           = lenErr_q;
    assign o_fcs_err           = fcsErr_q;
    assign o_frame_abort       = abort_q;

endmodule

// File: tb/tb_eth_rx_frame_analyzer_nd.sv
// tb_eth_rx_frame_analyzer_nd: directed frames against a frame-level expectation model.
// Honours ETH_RX_FCS_CHECK_EN so the FCS expectations follow the build of the design.
`timescale 1ns/1ps
module tb_eth_rx_frame_analyzer_nd;

    localparam int cDelay = 5;
`ifdef ETH_RX_FCS_CHECK_EN
    localparam bit cFcsOn = 1'b1;
`else
    localparam bit cFcsOn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstN = 1'b1;
    logic        rxDv = 1'b0;
    logic        rxEr = 1'b0;
    logic [7:0]  rxD = 8'h00;
    logic [2:0]  fsmState;
    logic        fsmChanged, dvDly, erDly, frameDone, frameOk, lenErr, fcsErr, frameAbort;
    logic [7:0]  dDly;
    logic [15:0] frameLen;

    int nVec = 0;
    int nMis = 0;

    // Expectation for the byte about to be sampled, filled in by applyStimulus.
    logic        pValid = 1'b0;
    logic [2:0]  pSt = 3'd0;
    logic        pDone = 1'b0, pOk = 1'b0, pLenErr = 1'b0, pFcsErr = 1'b0, pAbort = 1'b0;
    int          pLen = 0;

    logic [9:0]  hist[$];
    int          lastRst = -1;
    logic [2:0]  prevSt = 3'd0;
    int          mLen = 0;

    eth_rx_frame_analyzer_nd #(
        .pDELAY(cDelay), .pPRE_MIN(7), .pMIN_LEN(64), .pMAX_LEN(1518)
    ) dut (
        .i_rx_clk(clk), .i_rst_n(rstN), .i_rx_dv(rxDv), .i_rx_er(rxEr), .i_rx_d(rxD),
        .o_fsm_state(fsmState), .o_fsm_state_changed(fsmChanged),
        .o_rx_dv_dly(dvDly), .o_rx_er_dly(erDly), .o_rx_d_dly(dDly),
        .o_frame_len(frameLen), .o_frame_done(frameDone), .o_frame_ok(frameOk),
        .o_len_err(lenErr), .o_fcs_err(fcsErr), .o_frame_abort(frameAbort)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("[TB] FAIL %s at %0t: got %0h, required %0h", name, $time, act, exp);
        end
    endtask

    // Standard Ethernet FCS of the first n bytes, computed one bit at a time.
    function automatic logic [31:0] fcsOf(input logic [7:0] q[$], input int n);
        logic [31:0] crc;
        logic        fb;
        crc = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 8; j++) begin
                fb  = crc[0] ^ q[i][j];
                crc = crc >> 1;
                if (fb) crc = crc ^ 32'hEDB88320;
            end
        end
        return ~crc;
    endfunction

    task automatic applyStimulus(input logic rstn, input logic dv, input logic er, input logic [7:0] d,
                                 input logic [2:0] st, input logic done, input logic ok,
                                 input logic le, input logic fe, input logic ab, input int len);
        rstN = rstn; rxDv = dv; rxEr = er; rxD = d;
        pSt = st; pDone = done; pOk = ok; pLenErr = le; pFcsErr = fe; pAbort = ab; pLen = len;
        pValid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 8'h00, 3'd0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic preamble(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1, 1, 0, 8'h55, 3'd1, 0, 0, 0, 0, 0, 0);
    endtask

    // One frame: nPre preamble bytes, SFD, nData bytes whose last four are the FCS, then dv low.
    // flipAt corrupts a byte after the FCS is formed; erAt raises rx_er; rstAt pulses reset.
    task automatic sendFrame(input int nPre, input int nData, input int flipAt,
                             input int erAt, input int rstAt);
        logic [7:0]  fr[$];
        logic [7:0]  v;
        logic [31:0] fcs, rxFcs;
        bit          lb, fb;
        int          phase;
        fr = {};
        for (int i = 0; i < nData - 4; i++) begin
            v = 8'(i * 13 + 7);
            if (v == 8'h55) v = 8'h56;
            fr.push_back(v);
        end
        fcs = fcsOf(fr, nData - 4);
        for (int b = 0; b < 4; b++) fr.push_back(fcs[8*b +: 8]);
        if (flipAt >= 0) fr[flipAt] = fr[flipAt] ^ 8'h01;
        rxFcs = {fr[nData-1], fr[nData-2], fr[nData-3], fr[nData-4]};
        lb = (nData < 64) || (nData > 1518);
        fb = cFcsOn && (fcsOf(fr, nData - 4) != rxFcs);
        preamble(nPre);
        applyStimulus(1, 1, 0, 8'hD5, 3'd2, 0, 0, 0, 0, 0, 0);
        phase = 0;
        for (int i = 0; i < nData; i++) begin
            if (i == rstAt) begin
                applyStimulus(0, 1, 0, fr[i], 3'd0, 0, 0, 0, 0, 0, 0);
                phase = 1;
            end else if (phase == 1) begin
                applyStimulus(1, 1, 0, fr[i], 3'd5, 0, 0, 0, 0, 1, 0);
                phase = 2;
            end else if (phase == 2) begin
                applyStimulus(1, 1, 0, fr[i], 3'd5, 0, 0, 0, 0, 0, 0);
            end else if (i == erAt) begin
                applyStimulus(1, 1, 1, fr[i], 3'd5, 0, 0, 0, 0, 1, 0);
                phase = 2;
            end else begin
                applyStimulus(1, 1, 0, fr[i], 3'd3, 0, 0, 0, 0, 0, 0);
            end
        end
        if (phase != 0)
            applyStimulus(1, 0, 0, 8'h00, 3'd0, 0, 0, 0, 0, 0, 0);
        else
            applyStimulus(1, 0, 0, 8'h00, 3'd4, 1, !lb && !fb, lb, fb, 0, nData);
    endtask

    // Compare process: snapshot the expectation at each edge, check every output half a cycle later.
    initial begin : compareProc
        logic [2:0] sSt;
        logic       sDone, sOk, sLe, sFe, sAb, sChg;
        logic [9:0] dlyExp;
        int         k, src;
        forever begin
            @(posedge clk);
            if (pValid) begin
                hist.push_back({rxDv, rxEr, rxD});
                k = hist.size() - 1;
                if (!rstN) begin
                    lastRst = k;
                    sSt = 3'd0; sDone = 0; sOk = 0; sLe = 0; sFe = 0; sAb = 0; sChg = 0;
                    prevSt = 3'd0;
                    mLen = 0;
                end else begin
                    sSt = pSt; sDone = pDone; sOk = pOk; sLe = pLenErr; sFe = pFcsErr; sAb = pAbort;
                    sChg = (pSt != prevSt);
                    prevSt = pSt;
                    if (pDone) mLen = pLen;
                end
                src = k - cDelay + 1;
                dlyExp = (src >= 0 && src > lastRst) ? hist[src] : 10'd0;
                @(negedge clk);
                checkOutput("state", 32'(fsmState), 32'(sSt));
                checkOutput("changed", 32'(fsmChanged), 32'(sChg));
                checkOutput("done", 32'(frameDone), 32'(sDone));
                checkOutput("ok", 32'(frameOk), 32'(sOk));
                checkOutput("len_err", 32'(lenErr), 32'(sLe));
                checkOutput("fcs_err", 32'(fcsErr), 32'(sFe));
                checkOutput("abort", 32'(frameAbort), 32'(sAb));
                checkOutput("frame_len", 32'(frameLen), 32'(mLen));
                checkOutput("dv_dly", 32'(dvDly), 32'(dlyExp[9]));
                checkOutput("er_dly", 32'(erDly), 32'(dlyExp[8]));
                checkOutput("d_dly", 32'(dDly), 32'(dlyExp[7:0]));
            end
        end
    end

    // Directed sequence with a few literal pins on top of the model.
    initial begin : mainSeq
        logic [7:0] ref9[$];
        ref9 = {};
        for (int i = 0; i < 9; i++) ref9.push_back(8'(8'h31 + i));
        checkOutput("lit_crc_model", fcsOf(ref9, 9), 32'hCBF43926);

        applyStimulus(0, 0, 0, 8'h00, 3'd0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 8'h00, 3'd0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("lit_reset_state", 32'(fsmState), 32'd0);
        idle(2);

        // Lone 0xA5 byte: error from IDLE, and it reappears on the delay outputs 5 cycles later.
        applyStimulus(1, 1, 0, 8'hA5, 3'd5, 0, 0, 0, 0, 1, 0);
        idle(3);
        @(negedge clk);
        checkOutput("lit_dly_early", 32'(dvDly), 32'd0);
        idle(1);
        @(negedge clk);
        checkOutput("lit_dly_d", 32'(dDly), 32'hA5);
        checkOutput("lit_dly_dv", 32'(dvDly), 32'd1);
        idle(1);
        @(negedge clk);
        checkOutput("lit_dly_late", 32'(dvDly), 32'd0);
        idle(1);

        sendFrame(7, 64, -1, -1, -1);
        @(negedge clk);
        checkOutput("lit_len64", 32'(frameLen), 32'd64);
        checkOutput("lit_ok64", 32'(frameOk), 32'd1);
        checkOutput("lit_done64", 32'(frameDone), 32'd1);
        idle(2);

        sendFrame(7, 64, 10, -1, -1);
        @(negedge clk);
        checkOutput("lit_flip_ok", 32'(frameOk), cFcsOn ? 32'd0 : 32'd1);
        checkOutput("lit_flip_fcs", 32'(fcsErr), cFcsOn ? 32'd1 : 32'd0);
        idle(2);

        sendFrame(7, 40, -1, -1, -1);
        @(negedge clk);
        checkOutput("lit_len40", 32'(frameLen), 32'd40);
        checkOutput("lit_lenerr40", 32'(lenErr), 32'd1);
        idle(1);

        sendFrame(7, 63, -1, -1, -1);
        idle(1);
        sendFrame(7, 1518, -1, -1, -1);
        idle(1);
        sendFrame(7, 1519, -1, -1, -1);
        @(negedge clk);
        checkOutput("lit_lenerr1519", 32'(lenErr), 32'd1);
        idle(2);

        // Back-to-back frames: the next preamble starts on the END cycle's successor.
        sendFrame(7, 64, -1, -1, -1);
        sendFrame(8, 70, -1, -1, -1);
        idle(1);

        // Long preamble must saturate the count rather than wrap below the minimum.
        sendFrame(17, 64, -1, -1, -1);
        idle(1);

        sendFrame(7, 64, -1, 20, -1);
        @(negedge clk);
        checkOutput("lit_er_state", 32'(fsmState), 32'd0);
        checkOutput("lit_er_nodone", 32'(frameDone), 32'd0);
        idle(1);

        sendFrame(7, 64, -1, -1, 30);
        @(negedge clk);
        checkOutput("lit_rst_len", 32'(frameLen), 32'd0);
        idle(1);

        // Short preamble before SFD is an error.
        preamble(4);
        applyStimulus(1, 1, 0, 8'hD5, 3'd5, 0, 0, 0, 0, 1, 0);
        applyStimulus(1, 1, 0, 8'h12, 3'd5, 0, 0, 0, 0, 0, 0);
        idle(1);

        // Preamble abandoned quietly when dv drops.
        preamble(3);
        idle(2);

        // SFD followed directly by dv low: zero-length frame.
        preamble(7);
        applyStimulus(1, 1, 0, 8'hD5, 3'd2, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 8'h00, 3'd4, 1, 0, 1, cFcsOn, 0, 0);
        @(negedge clk);
        checkOutput("lit_len0", 32'(frameLen), 32'd0);
        idle(3);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule

// File: doc/eth_rx_frame_analyzer_nd.md
ETH_RX_FRAME_ANALYZER_ND -- requirements
Module: eth_rx_frame_analyzer_nd

Interface
REQ-001 SHALL have parameter pDELAY, default 4, meaning the data-path delay in cycles (legal 1..16).
REQ-002 SHALL have parameter pPRE_MIN, default 7, meaning the minimum 0x55 bytes required before SFD (legal 1..7).
REQ-003 SHALL have parameter pMIN_LEN, default 64, meaning the minimum legal frame length in bytes, FCS included.
REQ-004 SHALL have parameter pMAX_LEN, default 1518, meaning the maximum legal frame length in bytes, FCS included.
REQ-005 SHALL have ports:
- i_rx_clk  in  1  sole clock, one clock domain
- i_rst_n  in  1  reset, synchronous, active-low
- i_rx_dv  in  1  GMII data valid
- i_rx_er  in  1  GMII receive error
- i_rx_d  in  8  GMII data
- o_fsm_state  out  3  current state
- o_fsm_state_changed  out  1  state differs from previous cycle
- o_rx_dv_dly, o_rx_er_dly  out  1 each  delayed dv/er
- o_rx_d_dly  out  8  delayed data
- o_frame_len  out  16  DATA byte count of last frame
- o_frame_done  out  1  end-of-frame pulse
- o_frame_ok  out  1  valid with done: no length or FCS error
- o_len_err  out  1  valid with done: length out of range
- o_fcs_err  out  1  valid with done: FCS mismatch
- o_frame_abort  out  1  error-entry pulse

Function
REQ-006 SHALL register all outputs; state reflects the byte sampled on the same edge (1-cycle latency).
REQ-007 SHALL encode states as IDLE=0, PREAMBLE=1, SFD=2, DATA=3, END=4, ERROR=5; codes 6-7 SHALL go to IDLE.
REQ-008 From IDLE or END: dv&!er&d==0x55 -> PREAMBLE (preamble count=1); dv with any other d, or er -> ERROR; !dv -> IDLE.
REQ-009 From PREAMBLE: !dv -> IDLE with no flags; er -> ERROR; d==0x55 -> stay, count saturating at 15; d==0xD5 with count>=pPRE_MIN -> SFD; else -> ERROR.
REQ-010 From SFD: dv&!er -> DATA with length=1; !dv -> END with length=0; er -> ERROR.
REQ-011 From DATA: dv&!er -> stay, length+1 saturating at 0xFFFF; !dv -> END; er -> ERROR.
REQ-012 From ERROR: stay while dv=1; !dv -> IDLE.
REQ-013 The END cycle SHALL pulse o_frame_done for one cycle and present o_frame_len, o_len_err (len<pMIN_LEN or len>pMAX_LEN), o_fcs_err, and o_frame_ok=!len_err&!fcs_err; all four flags SHALL be 0 outside END.
REQ-014 o_frame_len SHALL hold its value until the next END.
REQ-015 o_frame_abort SHALL pulse one cycle on every entry to ERROR; ERROR SHALL never produce o_frame_done.
REQ-016 o_fsm_state_changed SHALL be 1 exactly when o_fsm_state differs from its prior-cycle value.
REQ-017 o_rx_*_dly at cycle t SHALL equal i_rx_* at cycle t-pDELAY, independent of FSM state.

Reset
REQ-018 i_rst_n=0 at an edge SHALL set state=IDLE, counters=0, CRC=0xFFFFFFFF, delay line=0 and every output=0 on the next cycle.
REQ-019 Reset mid-frame SHALL discard the frame; trailing bytes after release follow REQ-008.

Configuration
REQ-020 Macro ETH_RX_FCS_CHECK_EN defined: CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF) over DATA bytes; o_fcs_err=1 unless residue==0xC704DD7B at END.
REQ-021 Macro undefined: no CRC logic; o_fcs_err constant 0.

Verification
REQ-022 7x0x55, 0xD5, 64-byte frame with valid FCS, dv low -> states 1,2,3..3,4; done=1, len=64, ok=1, len_err=0, fcs_err=0.
REQ-023 Same frame, payload byte 10 XOR 0x01 -> macro on: fcs_err=1, ok=0; macro off: ok=1.
REQ-024 Valid 40-byte frame -> len=40, len_err=1, ok=0; 1519-byte frame -> len_err=1.
REQ-025 i_rx_er=1 for one cycle at DATA byte 20 -> abort pulse, state 5 until dv low, then 0; no done.
REQ-026 i_rst_n low one cycle at DATA byte 30 -> all outputs 0 next cycle; remaining bytes -> ERROR; IDLE after dv low.
REQ-027 pDELAY=5, single byte 0xA5 with dv at cycle t -> o_rx_d_dly=0xA5, o_rx_dv_dly=1 exactly at t+5; 4x0x55+0xD5 with pPRE_MIN=7 -> ERROR.
